// File: rtl/mem_bus_arbiter_pkg.sv
// ============================================================================
// Module : mem_bus_arbiter_pkg
// Brief  : Shared bus types and arbiter state encoding.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_bus_arbiter_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  wstrobe_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    GRANT_FETCH = 2'd1,
    GRANT_DATA  = 2'd2
  } arbiter_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_bus_arbiter_if.sv
// ============================================================================
// Module : mem_bus_arbiter_if
// Brief  : Requester-side and memory-side signals of the shared core bus.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  logic     fetch_valid;
  word_t    fetch_address;
  logic     fetch_ready;
  word_t    fetch_rdata;

  logic     data_valid;
  word_t    data_address;
  wstrobe_t data_wstrobe;
  word_t    data_wdata;
  logic     data_ready;
  word_t    data_rdata;

  logic     mem_valid;
  logic     mem_instr;
  word_t    mem_address;
  wstrobe_t mem_wstrobe;
  word_t    mem_wdata;
  logic     mem_ready;
  word_t    mem_rdata;

  // Arbiter as the target of the two requesters
  modport slave (
    input  fetch_valid, fetch_address,
    input  data_valid, data_address, data_wstrobe, data_wdata,
    output fetch_ready, fetch_rdata, data_ready, data_rdata
  );

  // Arbiter as the initiator on the memory bus
  modport master (
    output mem_valid, mem_instr, mem_address, mem_wstrobe, mem_wdata,
    input  mem_ready, mem_rdata
  );

endinterface

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module : mem_bus_arbiter
// Brief  : Two-requester (fetch / data) arbiter for the single memory bus.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  mem_bus_arbiter_if.slave        req,
  mem_bus_arbiter_if.master       mem
);

  arbiter_state_t r_state;
  arbiter_state_t w_state_next;
  logic           r_last_grant;
  logic           w_last_grant_next;

  logic           w_mem_valid;
  logic           w_mem_instr;
  word_t          w_mem_address;
  wstrobe_t       w_mem_wstrobe;
  word_t          w_mem_wdata;
  logic           w_fetch_ready;
  logic           w_data_ready;

  // last_data is the requester treated as most recently served (1 = data)
  function automatic arbiter_state_t select_grant(input logic fetch_v,
                                                  input logic data_v,
                                                  input logic last_data);
    if (fetch_v && data_v)
      return ((ROUND_ROBIN != 0) && last_data) ? GRANT_FETCH : GRANT_DATA;
    else if (fetch_v)
      return GRANT_FETCH;
    else if (data_v)
      return GRANT_DATA;
    else
      return IDLE;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_last_grant <= w_last_grant_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_last_grant_next = r_last_grant;
    w_mem_valid       = 1'b0;
    w_mem_instr       = 1'b0;
    w_mem_address     = '0;
    w_mem_wstrobe     = '0;
    w_mem_wdata       = '0;
    w_fetch_ready     = 1'b0;
    w_data_ready      = 1'b0;

    case (r_state)
      IDLE: begin
        w_state_next = select_grant(req.fetch_valid, req.data_valid, r_last_grant);
      end

      GRANT_FETCH: begin
        w_mem_valid   = req.fetch_valid;
        w_mem_instr   = 1'b1;
        w_mem_address = req.fetch_address;
        w_fetch_ready = mem.mem_ready && req.fetch_valid;
        // A requester abandoning its request returns the bus to arbitration
        if (!req.fetch_valid) begin
          w_state_next = IDLE;
        end else if (mem.mem_ready) begin
          w_last_grant_next = 1'b0;
          w_state_next      = select_grant(req.fetch_valid, req.data_valid, 1'b0);
        end
      end

      GRANT_DATA: begin
        w_mem_valid   = req.data_valid;
        w_mem_address = req.data_address;
        w_mem_wstrobe = req.data_wstrobe;
        w_mem_wdata   = req.data_wdata;
        w_data_ready  = mem.mem_ready && req.data_valid;
        if (!req.data_valid) begin
          w_state_next = IDLE;
        end else if (mem.mem_ready) begin
          w_last_grant_next = 1'b1;
          w_state_next      = select_grant(req.fetch_valid, req.data_valid, 1'b1);
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign mem.mem_valid   = w_mem_valid;
  assign mem.mem_instr   = w_mem_instr;
  assign mem.mem_address = w_mem_address;
  assign mem.mem_wstrobe = w_mem_wstrobe;
  assign mem.mem_wdata   = w_mem_wdata;
  assign req.fetch_ready = w_fetch_ready;
  assign req.data_ready  = w_data_ready;
  assign req.fetch_rdata = mem.mem_rdata;
  assign req.data_rdata  = mem.mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module : tb_mem_bus_arbiter
// Brief  : Scoreboard bench for mem_bus_arbiter (round-robin and fixed priority).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

  typedef struct {
    logic        instr;
    logic [31:0] addr;
    logic [3:0]  wstrobe;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;
  int fetch_cnt0 = 0, data_cnt0 = 0, fetch_cnt1 = 0, data_cnt1 = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  mem_bus_arbiter_if b0();
  mem_bus_arbiter_if b1();

  mem_bus_arbiter #(.ROUND_ROBIN(1)) u_dut_rr (
    .clk   (clk),
    .reset (reset),
    .req   (b0),
    .mem   (b0)
  );

  mem_bus_arbiter #(.ROUND_ROBIN(0)) u_dut_fp (
    .clk   (clk),
    .reset (reset),
    .req   (b1),
    .mem   (b1)
  );

  always #5 clk = ~clk;

  function automatic exp_t item(input logic instr, input logic [31:0] addr,
                                input logic [3:0] ws, input logic [31:0] wd,
                                input logic [31:0] rd);
    exp_t e;
    e.instr = instr; e.addr = addr; e.wstrobe = ws; e.wdata = wd; e.rdata = rd;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cmp_item(input string tag, input exp_t e,
                          input logic mv, input logic mi,
                          input logic [31:0] ma, input logic [3:0] ms,
                          input logic [31:0] mw, input logic fr, input logic dr,
                          input logic [31:0] frd, input logic [31:0] drd);
    chk({tag, " mem_valid"}, {31'd0, mv}, 32'd1);
    chk({tag, " mem_instr"}, {31'd0, mi}, {31'd0, e.instr});
    chk({tag, " mem_address"}, ma, e.addr);
    chk({tag, " mem_wstrobe"}, {28'd0, ms}, {28'd0, e.wstrobe});
    if (!e.instr) chk({tag, " mem_wdata"}, mw, e.wdata);
    chk({tag, " fetch_ready"}, {31'd0, fr}, {31'd0, e.instr});
    chk({tag, " data_ready"}, {31'd0, dr}, {31'd0, !e.instr});
    chk({tag, " rdata"}, e.instr ? frd : drd, e.rdata);
  endtask

  // Scoreboard monitors: pop one expected transfer per completion or ready
  always @(negedge clk) begin
    if (b0.fetch_ready) fetch_cnt0++;
    if (b0.data_ready)  data_cnt0++;
    if (!reset && ((b0.mem_valid && b0.mem_ready) || b0.fetch_ready || b0.data_ready)) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL rr unexpected transfer addr=%h instr=%0d expected none",
                 b0.mem_address, b0.mem_instr);
      end else begin
        e0 = q0.pop_front();
        cmp_item("rr", e0, b0.mem_valid, b0.mem_instr, b0.mem_address, b0.mem_wstrobe,
                 b0.mem_wdata, b0.fetch_ready, b0.data_ready, b0.fetch_rdata, b0.data_rdata);
      end
    end
  end

  always @(negedge clk) begin
    if (b1.fetch_ready) fetch_cnt1++;
    if (b1.data_ready)  data_cnt1++;
    if (!reset && ((b1.mem_valid && b1.mem_ready) || b1.fetch_ready || b1.data_ready)) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL fp unexpected transfer addr=%h instr=%0d expected none",
                 b1.mem_address, b1.mem_instr);
      end else begin
        e1 = q1.pop_front();
        cmp_item("fp", e1, b1.mem_valid, b1.mem_instr, b1.mem_address, b1.mem_wstrobe,
                 b1.mem_wdata, b1.fetch_ready, b1.data_ready, b1.fetch_rdata, b1.data_rdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic clear_counts();
    fetch_cnt0 = 0; data_cnt0 = 0; fetch_cnt1 = 0; data_cnt1 = 0;
  endtask

  initial begin
    b0.fetch_valid = 1'b0; b0.fetch_address = '0;
    b0.data_valid = 1'b0; b0.data_address = '0; b0.data_wstrobe = '0; b0.data_wdata = '0;
    b0.mem_ready = 1'b0; b0.mem_rdata = '0;
    b1.fetch_valid = 1'b0; b1.fetch_address = '0;
    b1.data_valid = 1'b0; b1.data_address = '0; b1.data_wstrobe = '0; b1.data_wdata = '0;
    b1.mem_ready = 1'b0; b1.mem_rdata = '0;

    // Reset state
    step(); step();
    @(negedge clk);
    chk("reset mem_valid", {31'd0, b0.mem_valid}, 32'd0);
    chk("reset mem_instr", {31'd0, b0.mem_instr}, 32'd0);
    chk("reset fetch_ready", {31'd0, b0.fetch_ready}, 32'd0);
    chk("reset data_ready", {31'd0, b0.data_ready}, 32'd0);
    step(); reset = 1'b0;
    idle(2);

    // Fetch only, ack in second grant cycle
    clear_counts();
    b0.fetch_valid = 1'b1; b0.fetch_address = 32'h0000_0100;
    @(negedge clk);
    chk("fetch latency mem_valid", {31'd0, b0.mem_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("fetch grant mem_valid", {31'd0, b0.mem_valid}, 32'd1);
    chk("fetch grant mem_instr", {31'd0, b0.mem_instr}, 32'd1);
    chk("fetch grant mem_wstrobe", {28'd0, b0.mem_wstrobe}, 32'd0);
    chk("fetch grant fetch_ready", {31'd0, b0.fetch_ready}, 32'd0);
    step();
    q0.push_back(item(1'b1, 32'h0000_0100, 4'h0, 32'h0, 32'h0000_0013));
    b0.mem_ready = 1'b1; b0.mem_rdata = 32'h0000_0013;
    step();
    b0.fetch_valid = 1'b0; b0.mem_ready = 1'b0;
    idle(3);
    chk("fetch only fetch_ready count", fetch_cnt0, 32'd1);
    chk("fetch only data_ready count", data_cnt0, 32'd0);

    // Store with three wait states
    clear_counts();
    b0.data_valid = 1'b1; b0.data_address = 32'h0000_2002;
    b0.data_wstrobe = 4'b1100; b0.data_wdata = 32'hBEEF_BEEF;
    step();
    @(negedge clk);
    chk("store mem_address", b0.mem_address, 32'h0000_2002);
    chk("store mem_wstrobe", {28'd0, b0.mem_wstrobe}, 32'h0000_000C);
    chk("store mem_wdata", b0.mem_wdata, 32'hBEEF_BEEF);
    chk("store mem_instr", {31'd0, b0.mem_instr}, 32'd0);
    step(); step(); step();
    q0.push_back(item(1'b0, 32'h0000_2002, 4'b1100, 32'hBEEF_BEEF, 32'hDEAD_0000));
    b0.mem_ready = 1'b1; b0.mem_rdata = 32'hDEAD_0000;
    step();
    b0.data_valid = 1'b0; b0.mem_ready = 1'b0;
    idle(3);
    chk("store data_ready count", data_cnt0, 32'd1);
    chk("store fetch_ready count", fetch_cnt0, 32'd0);

    // Simultaneous requests out of reset, zero-wait memory
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_counts();
    b0.fetch_valid = 1'b1; b0.fetch_address = 32'h0000_0200;
    b0.data_valid = 1'b1; b0.data_address = 32'h0000_3000;
    b0.data_wstrobe = 4'h0; b0.data_wdata = 32'h0;
    b0.mem_ready = 1'b1; b0.mem_rdata = 32'h0000_0055;
    for (int i = 0; i < 4; i++)
      q0.push_back(item((i % 2) == 0, (i % 2) == 0 ? 32'h0000_0200 : 32'h0000_3000,
                        4'h0, 32'h0, 32'h0000_0055));
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      chk("rr back-to-back mem_valid", {31'd0, b0.mem_valid}, 32'd1);
    end
    step();
    b0.fetch_valid = 1'b0; b0.data_valid = 1'b0; b0.mem_ready = 1'b0;
    idle(3);
    chk("rr fetch count", fetch_cnt0, 32'd2);
    chk("rr data count", data_cnt0, 32'd2);

    // Fixed priority: data starves fetch until it drops
    clear_counts();
    b1.fetch_valid = 1'b1; b1.fetch_address = 32'h0000_0400;
    b1.data_valid = 1'b1; b1.data_address = 32'h0000_5004;
    b1.data_wstrobe = 4'hF; b1.data_wdata = 32'h1234_5678;
    b1.mem_ready = 1'b1; b1.mem_rdata = 32'h0000_00A5;
    for (int i = 0; i < 3; i++)
      q1.push_back(item(1'b0, 32'h0000_5004, 4'hF, 32'h1234_5678, 32'h0000_00A5));
    q1.push_back(item(1'b1, 32'h0000_0400, 4'h0, 32'h0, 32'h0000_00A5));
    step(); step(); step(); step();
    b1.data_valid = 1'b0;
    chk("fp fetch starved count", fetch_cnt1, 32'd0);
    step(); step(); step();
    b1.fetch_valid = 1'b0; b1.mem_ready = 1'b0;
    idle(3);
    chk("fp data count", data_cnt1, 32'd3);
    chk("fp fetch count", fetch_cnt1, 32'd1);

    // Reset asserted mid-grant abandons the transfer
    clear_counts();
    b0.data_valid = 1'b1; b0.data_address = 32'h0000_6000;
    b0.data_wstrobe = 4'h0; b0.data_wdata = 32'h0;
    step();
    @(negedge clk);
    chk("pre-reset mem_valid", {31'd0, b0.mem_valid}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async reset mem_valid", {31'd0, b0.mem_valid}, 32'd0);
    chk("async reset data_ready", {31'd0, b0.data_ready}, 32'd0);
    chk("async reset fetch_ready", {31'd0, b0.fetch_ready}, 32'd0);
    b0.mem_ready = 1'b1;
    #1;
    chk("reset blocks data_ready", {31'd0, b0.data_ready}, 32'd0);
    b0.mem_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset idle mem_valid", {31'd0, b0.mem_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("re-arbitrated mem_valid", {31'd0, b0.mem_valid}, 32'd1);
    chk("re-arbitrated mem_instr", {31'd0, b0.mem_instr}, 32'd0);
    step();
    q0.push_back(item(1'b0, 32'h0000_6000, 4'h0, 32'h0, 32'h0000_0077));
    b0.mem_ready = 1'b1; b0.mem_rdata = 32'h0000_0077;
    step();
    b0.data_valid = 1'b0; b0.mem_ready = 1'b0;
    idle(3);
    chk("reset test data count", data_cnt0, 32'd1);

    // Granted fetch drops valid before ready
    clear_counts();
    b0.fetch_valid = 1'b1; b0.fetch_address = 32'h0000_0800;
    b0.data_valid = 1'b1; b0.data_address = 32'h0000_7008;
    b0.data_wstrobe = 4'b0011; b0.data_wdata = 32'h0000_CAFE;
    step();
    @(negedge clk);
    chk("violation grant mem_instr", {31'd0, b0.mem_instr}, 32'd1);
    chk("violation grant mem_valid", {31'd0, b0.mem_valid}, 32'd1);
    step();
    b0.fetch_valid = 1'b0;
    #1;
    chk("violation same-cycle mem_valid", {31'd0, b0.mem_valid}, 32'd0);
    chk("violation fetch_ready", {31'd0, b0.fetch_ready}, 32'd0);
    step();
    @(negedge clk);
    chk("violation idle mem_valid", {31'd0, b0.mem_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("violation data grant mem_valid", {31'd0, b0.mem_valid}, 32'd1);
    chk("violation data grant mem_instr", {31'd0, b0.mem_instr}, 32'd0);
    step();
    q0.push_back(item(1'b0, 32'h0000_7008, 4'b0011, 32'h0000_CAFE, 32'h0000_0099));
    b0.mem_ready = 1'b1; b0.mem_rdata = 32'h0000_0099;
    step();
    b0.data_valid = 1'b0; b0.mem_ready = 1'b0;
    idle(3);
    chk("violation fetch count", fetch_cnt0, 32'd0);
    chk("violation data count", data_cnt0, 32'd1);

    chk("rr scoreboard drained", q0.size(), 32'd0);
    chk("fp scoreboard drained", q1.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
